sevenseg_scan_ctrl: RTL

//  Time-multiplexes NDIGITS hex digits onto a common-segment LED display

---
 rtl/sevenseg_pkg.sv | 18 +
 rtl/sevenseg_scan_ctrl_decoder.sv | 32 +++
 rtl/sevenseg_scan_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   scan_state_t : GUARD (all dark between digits) / SHOW (one digit lit)
//   SEG_OFF      : active-low segment pattern with every segment dark
//   cnt_width()  : bit width of a counter that runs 0..max_count-1
package sevenseg_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_decoder.sv
// Hex nibble to active-low seven-segment pattern.
//   hex_i   : nibble to display
//   seg_n_o : active-low segments {g,f,e,d,c,b,a}
module sevenseg_scan_ctrl_decoder (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = 7'h7F;
        case (hex_i)
            4'h0: seg_n_o = 7'b1000000;
            4'h1: seg_n_o = 7'b1111001;
            4'h2: seg_n_o = 7'b0100100;
            4'h3: seg_n_o = 7'b0110000;
            4'h4: seg_n_o = 7'b0011001;
            4'h5: seg_n_o = 7'b0010010;
            4'h6: seg_n_o = 7'b0000010;
            4'h7: seg_n_o = 7'b1111000;
            4'h8: seg_n_o = 7'b0000000;
            4'h9: seg_n_o = 7'b0010000;
            4'hA: seg_n_o = 7'b0001000;
            4'hB: seg_n_o = 7'b0000011;
            4'hC: seg_n_o = 7'b1000110;
            4'hD: seg_n_o = 7'b0100001;
            4'hE: seg_n_o = 7'b0000110;
            4'hF: seg_n_o = 7'b0001110;
            default: seg_n_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed driver for an NDIGITS common-segment hex display.
// Each digit is lit for REFRESH_DIV clocks, followed by BLANK_CYCLES clocks
// of all-dark guard to suppress ghosting. A loaded value is held pending and
// only copied into the displayed (shadow) value at the frame boundary.
//   clock, reset : system clock; asynchronous active-high reset
//   value        : nibble i drives digit i
//   load / ready : capture request / no update pending
//   blank_mask   : live per-digit blanking
//   anode_n      : active-low digit strobes
//   segments_n   : active-low segments {g,f,e,d,c,b,a}
//   frame_tick   : pulse on the first lit cycle of digit 0
//
// state | meaning
// ------+-----------------------------------------------------------
// GUARD | all digits dark; counts BLANK_CYCLES then advances digit
// SHOW  | anode_n[digit] low, segments decoded; counts REFRESH_DIV
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NDIGITS      = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic                   load,
    output logic                   ready,
    input  logic [NDIGITS-1:0]     blank_mask,
    output logic [NDIGITS-1:0]     anode_n,
    output logic [6:0]             segments_n,
    output logic                   frame_tick
);

    localparam int CW = cnt_width((REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES);
    localparam int DW = $clog2(NDIGITS);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NDIGITS - 1);

    scan_state_t                  state_q, state_d;
    logic [DW-1:0]                digit_q, digit_d;
    logic [CW-1:0]                count_q, count_d;
    logic [NDIGITS-1:0][3:0]      shadow_q, shadow_d;
    logic [NDIGITS-1:0][3:0]      pend_val_q, pend_val_d;
    logic                         pend_q, pend_d;

    logic                         boundary;
    logic                         lit;
    logic [6:0]                   dec_seg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= GUARD;
            digit_q    <= DIGIT_LAST;
            count_q    <= '0;
            shadow_q   <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            count_q    <= count_d;
            shadow_q   <= shadow_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        count_d    = count_q;
        shadow_d   = shadow_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        boundary   = 1'b0;

        case (state_q)
            SHOW: begin
                if (count_q == SHOW_LAST) begin
                    state_d = GUARD;
                    count_d = '0;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            GUARD: begin
                if (count_q == GUARD_LAST) begin
                    state_d = SHOW;
                    count_d = '0;
                    if (digit_q == DIGIT_LAST) begin
                        digit_d  = '0;
                        boundary = 1'b1;
                    end else begin
                        digit_d = digit_q + DW'(1);
                    end
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: state_d = GUARD;
        endcase

        // Commit and capture are mutually exclusive: commit needs pend_q=1,
        // capture needs pend_q=0. A load landing on the boundary therefore
        // waits for the next frame.
        if (boundary && pend_q) begin
            shadow_d = pend_val_q;
            pend_d   = 1'b0;
        end
        if (load && !pend_q) begin
            pend_val_d = value;
            pend_d     = 1'b1;
        end
    end

    sevenseg_scan_ctrl_decoder u_dec (
        .hex_i   (shadow_q[digit_q]),
        .seg_n_o (dec_seg)
    );

    always_comb begin
        lit        = (state_q == SHOW) && !blank_mask[digit_q];
        anode_n    = '1;
        if (lit) begin
            anode_n[digit_q] = 1'b0;
        end
        segments_n = lit ? dec_seg : SEG_OFF;
        ready      = !pend_q;
        // Tick marks slot timing, so it is not suppressed by blanking.
        frame_tick = (state_q == SHOW) && (digit_q == '0) && (count_q == '0);
    end

endmodule
